// File: rtl/mojo_serial_frame_out_pkg.sv
// Shared types and constants for the serial frame output block.
package mojo_serial_frame_out_pkg;

  // Controller states: wait for a block, issue one byte, hold one guard cycle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEmit  = 2'd1,
    StGuard = 2'd2
  } state_e;

  // Which frame element the next issued byte comes from.
  typedef enum logic [1:0] {
    ElemHdr  = 2'd0,
    ElemData = 2'd1,
    ElemCsum = 2'd2
  } elem_e;

  localparam logic [7:0] DefaultHeaderByte = 8'hA5;

endpackage

// File: rtl/mojo_serial_frame_out_if.sv
// Producer-side block handshake plus the byte-wide UART transmit handshake.
interface mojo_serial_frame_out_if #(
  parameter int unsigned MAX_BYTES = 4
);
  localparam int unsigned LEN_BITS = $clog2(MAX_BYTES + 1);

  logic                   tx_busy;
  logic [7:0]             tx_data;
  logic                   new_tx_data;
  logic [MAX_BYTES*8-1:0] tx_block;
  logic [LEN_BITS-1:0]    tx_len;
  logic                   new_tx_block;
  logic                   block_ready;
  logic                   block_done;

  // Frame serialiser side.
  modport master (
    input  tx_busy, tx_block, tx_len, new_tx_block,
    output tx_data, new_tx_data, block_ready, block_done
  );

  // Producer / UART side.
  modport slave (
    output tx_busy, tx_block, tx_len, new_tx_block,
    input  tx_data, new_tx_data, block_ready, block_done
  );

endinterface

// File: rtl/mojo_serial_frame_out.sv
// Serialises a variable-length block (optional header and XOR trailer) onto a byte UART.
module mojo_serial_frame_out
  import mojo_serial_frame_out_pkg::*;
#(
  parameter int unsigned MAX_BYTES   = 4,
  parameter bit          MSB_FIRST   = 1'b0,
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [7:0]  HEADER_BYTE = DefaultHeaderByte,
  parameter bit          CHECKSUM_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  mojo_serial_frame_out_if.master bus
);

  localparam int unsigned LEN_BITS = $clog2(MAX_BYTES + 1);
  localparam int unsigned BW       = MAX_BYTES * 8;

  state_e              state_q, state_d;
  elem_e               elem_q, elem_d;
  logic [BW-1:0]       block_q, block_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                new_q, new_d;
  logic                done_q, done_d;
  logic                last_q, last_d;

  logic [LEN_BITS-1:0] cnt_inc;
  logic [LEN_BITS-1:0] idx;
  logic [BW-1:0]       shifted;
  logic [7:0]          data_byte;
  logic [7:0]          cur_byte;

  // Current data byte and the element byte that the next issue would send.
  always_comb begin
    cnt_inc   = cnt_q + LEN_BITS'(1);
    // Reverse order walks from len-1 down: len - (cnt + 1).
    idx       = MSB_FIRST ? (len_q - cnt_inc) : cnt_q;
    shifted   = block_q >> {idx, 3'b000};
    data_byte = shifted[7:0];
    unique case (elem_q)
      ElemHdr:  cur_byte = HEADER_BYTE;
      ElemData: cur_byte = data_byte;
      ElemCsum: cur_byte = csum_q;
      default:  cur_byte = 8'h00;
    endcase
  end

  // Next-state logic for the frame controller.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    block_d   = block_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    new_d     = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.new_tx_block && (bus.tx_len != '0)) begin
          block_d = bus.tx_block;
          len_d   = (bus.tx_len > LEN_BITS'(MAX_BYTES)) ? LEN_BITS'(MAX_BYTES) : bus.tx_len;
          cnt_d   = '0;
          csum_d  = 8'h00;
          elem_d  = HEADER_EN ? ElemHdr : ElemData;
          last_d  = 1'b0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (!bus.tx_busy) begin
          tx_data_d = cur_byte;
          new_d     = 1'b1;
          state_d   = StGuard;
          unique case (elem_q)
            ElemHdr: elem_d = ElemData;
            ElemData: begin
              csum_d = csum_q ^ data_byte;
              cnt_d  = cnt_inc;
              if (cnt_inc == len_q) begin
                if (CHECKSUM_EN) elem_d = ElemCsum;
                else             last_d = 1'b1;
              end
            end
            default: last_d = 1'b1;
          endcase
        end
      end
      StGuard: begin
        // Busy is ignored here: the UART raises it one cycle after our strobe.
        if (last_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StEmit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      elem_q    <= ElemHdr;
      block_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      csum_q    <= 8'h00;
      tx_data_q <= 8'h00;
      new_q     <= 1'b0;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      block_q   <= block_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      tx_data_q <= tx_data_d;
      new_q     <= new_d;
      done_q    <= done_d;
      last_q    <= last_d;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_q;
  assign bus.block_ready = (state_q == StIdle);
  assign bus.block_done  = done_q;

endmodule

// File: tb/tb_mojo_serial_frame_out.sv
// Randomised self-checking bench for mojo_serial_frame_out against a frame-list model.
`timescale 1ns/1ps
module tb_mojo_serial_frame_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy_man;
  logic        busy_rnd = 1'b0;
  logic        rand_busy;
  logic        busy;
  logic [31:0] blk;
  logic [2:0]  len;
  logic        req;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  assign busy = rand_busy ? busy_rnd : busy_man;

  mojo_serial_frame_out_if #(.MAX_BYTES(4)) bus_a ();
  mojo_serial_frame_out_if #(.MAX_BYTES(4)) bus_b ();
  mojo_serial_frame_out_if #(.MAX_BYTES(4)) bus_c ();

  assign bus_a.tx_busy = busy;  assign bus_a.tx_block = blk;
  assign bus_a.tx_len  = len;   assign bus_a.new_tx_block = req;
  assign bus_b.tx_busy = busy;  assign bus_b.tx_block = blk;
  assign bus_b.tx_len  = len;   assign bus_b.new_tx_block = req;
  assign bus_c.tx_busy = busy;  assign bus_c.tx_block = blk;
  assign bus_c.tx_len  = len;   assign bus_c.new_tx_block = req;

  // a: LSB first, header + checksum; b: bare data; c: MSB first, header + checksum.
  mojo_serial_frame_out #(.MAX_BYTES(4), .MSB_FIRST(1'b0), .HEADER_EN(1'b1),
    .HEADER_BYTE(8'hA5), .CHECKSUM_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mojo_serial_frame_out #(.MAX_BYTES(4), .MSB_FIRST(1'b0), .HEADER_EN(1'b0),
    .HEADER_BYTE(8'hA5), .CHECKSUM_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  mojo_serial_frame_out #(.MAX_BYTES(4), .MSB_FIRST(1'b1), .HEADER_EN(1'b1),
    .HEADER_BYTE(8'hA5), .CHECKSUM_EN(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  logic [7:0] mon_a[$], mon_b[$], mon_c[$];
  int         st_a[$], st_b[$];
  int         dn_a[$], dn_b[$], dn_c[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) busy_rnd <= ($urandom_range(0, 2) == 0);

  // Record every strobed byte and done pulse, away from the active edge.
  always @(negedge clk) begin
    if (bus_a.new_tx_data) begin mon_a.push_back(bus_a.tx_data); st_a.push_back(cyc); end
    if (bus_b.new_tx_data) begin mon_b.push_back(bus_b.tx_data); st_b.push_back(cyc); end
    if (bus_c.new_tx_data) mon_c.push_back(bus_c.tx_data);
    if (bus_a.block_done) dn_a.push_back(cyc);
    if (bus_b.block_done) dn_b.push_back(cyc);
    if (bus_c.block_done) dn_c.push_back(cyc);
  end

  // Expected byte list for one frame, appended to exp_q.
  task automatic model_frame(input logic [31:0] b, input int l, input bit msb,
                             input bit hdr, input bit cs);
    int n;
    logic [7:0] c, by;
    n = (l > 4) ? 4 : l;
    if (n == 0) return;
    if (hdr) exp_q.push_back(8'hA5);
    c = 8'h00;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = msb ? (n - 1 - k) : k;
      by  = b[idx*8 +: 8];
      exp_q.push_back(by);
      c ^= by;
    end
    if (cs) exp_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_a.delete(); mon_b.delete(); mon_c.delete();
    st_a.delete(); st_b.delete();
    dn_a.delete(); dn_b.delete(); dn_c.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; busy_man = 1'b0; rand_busy = 1'b0;
    blk = 32'h0; len = 3'd0;
    tick(2);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic send(input logic [31:0] b, input logic [2:0] l);
    blk = b; len = l; req = 1'b1;
    tick(1);
    req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_a.tx_data !== 8'h00 || bus_a.new_tx_data !== 1'b0 || bus_a.block_ready !== 1'b1
        || bus_a.block_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: data=%h new=%b ready=%b done=%b, want 00 0 1 0", bus_a.tx_data,
               bus_a.new_tx_data, bus_a.block_ready, bus_a.block_done);
    end
    checks++;
    if (bus_b.block_ready !== 1'b1 || bus_c.block_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_bc: b=%b c=%b, want 1 1", bus_b.block_ready, bus_c.block_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] want[6];
    want = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    do_reset();
    send(32'h44332211, 3'd4);
    tick(16);
    checks++;
    if (mon_a.size() != 6) begin
      failures++;
      $display("FAIL basic_count: got %0d pulses, want 6", mon_a.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= mon_a.size() || mon_a[i] !== want[i]) begin
        failures++;
        $display("FAIL basic_byte%0d: got %h, want %h", i,
                 (i < mon_a.size()) ? mon_a[i] : 8'hxx, want[i]);
      end
    end
    for (int i = 1; i < st_a.size(); i++) begin
      checks++;
      if (st_a[i] - st_a[i-1] != 2) begin
        failures++;
        $display("FAIL basic_spacing%0d: gap %0d, want 2", i, st_a[i] - st_a[i-1]);
      end
    end
    checks++;
    if (dn_a.size() != 1 || st_a.size() != 6 || dn_a[0] != st_a[5] + 1) begin
      failures++;
      $display("FAIL basic_done: %0d done pulses, want 1 one cycle after the last byte",
               dn_a.size());
    end
  endtask

  task automatic test_msb_first();
    do_reset();
    send(32'h1234BBAA, 3'd2);
    tick(12);
    model_frame(32'h1234BBAA, 2, 1'b1, 1'b1, 1'b1);
    checks++;
    if (mon_c.size() != exp_q.size()) begin
      failures++;
      $display("FAIL msb_count: got %0d, want %0d", mon_c.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= mon_c.size() || mon_c[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL msb_byte%0d: got %h, want %h", i,
                 (i < mon_c.size()) ? mon_c[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_stall();
    bit seen;
    do_reset();
    send(32'h44332211, 3'd4);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (bus_a.new_tx_data) seen = 1'b1;
      else tick(1);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL busy_first_pulse: no pulse within 5 cycles, want one");
    end
    busy_man = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (bus_a.new_tx_data !== 1'b0 || bus_a.tx_data !== 8'hA5) begin
        failures++;
        $display("FAIL busy_hold%0d: new=%b data=%h, want 0 a5", i, bus_a.new_tx_data,
                 bus_a.tx_data);
      end
    end
    busy_man = 1'b0;
    tick(1);
    checks++;
    if (bus_a.new_tx_data !== 1'b1 || bus_a.tx_data !== 8'h11) begin
      failures++;
      $display("FAIL busy_release: new=%b data=%h, want 1 11", bus_a.new_tx_data, bus_a.tx_data);
    end
    tick(16);
    model_frame(32'h44332211, 4, 1'b0, 1'b1, 1'b1);
    checks++;
    if (mon_a != exp_q) begin
      failures++;
      $display("FAIL busy_frame: got %p, want %p", mon_a, exp_q);
    end
  endtask

  task automatic test_len_edges();
    logic [31:0] b;
    do_reset();
    send(32'hDEADBEEF, 3'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++;
      if (bus_a.block_ready !== 1'b1 || bus_a.new_tx_data !== 1'b0) begin
        failures++;
        $display("FAIL len0_idle%0d: ready=%b new=%b, want 1 0", i, bus_a.block_ready,
                 bus_a.new_tx_data);
      end
    end
    b = $urandom;
    send(b, 3'd7);
    tick(20);
    model_frame(b, 7, 1'b0, 1'b1, 1'b1);
    checks++;
    if (mon_a != exp_q) begin
      failures++;
      $display("FAIL len_clamp: got %p, want %p", mon_a, exp_q);
    end
  endtask

  task automatic test_mid_reset();
    int cnt;
    logic [31:0] b;
    do_reset();
    send(32'h44332211, 3'd4);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      tick(1);
      if (bus_a.new_tx_data) cnt++;
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (bus_a.new_tx_data !== 1'b0 || bus_a.block_ready !== 1'b1 || bus_a.tx_data !== 8'h00
        || bus_a.block_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state: new=%b ready=%b data=%h done=%b, want 0 1 00 0",
               bus_a.new_tx_data, bus_a.block_ready, bus_a.tx_data, bus_a.block_done);
    end
    rst = 1'b0;
    tick(15);
    checks++;
    if (mon_a.size() != 2 || dn_a.size() != 0) begin
      failures++;
      $display("FAIL midrst_abort: %0d pulses %0d done, want 2 0", mon_a.size(), dn_a.size());
    end
    clear_mon();
    b = $urandom;
    send(b, 3'd3);
    tick(16);
    model_frame(b, 3, 1'b0, 1'b1, 1'b1);
    checks++;
    if (mon_a != exp_q) begin
      failures++;
      $display("FAIL midrst_after: got %p, want %p", mon_a, exp_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b1, b2;
    int l1, l2;
    bit hit;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      b1 = $urandom; b2 = $urandom;
      l1 = $urandom_range(1, 4); l2 = $urandom_range(1, 4);
      send(b1, 3'(l1));
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
        if (bus_b.block_done) begin
          blk = b2; len = 3'(l2); req = 1'b1;
          tick(1);
          req = 1'b0;
          hit = 1'b1;
        end else begin
          blk = $urandom; len = 3'($urandom_range(1, 7)); req = i[0];
          tick(1);
        end
      end
      req = 1'b0;
      checks++;
      if (!hit) begin
        failures++;
        $display("FAIL b2b_done%0d: first frame never completed, want done", it);
      end
      tick(20);
      model_frame(b1, l1, 1'b0, 1'b0, 1'b0);
      model_frame(b2, l2, 1'b0, 1'b0, 1'b0);
      checks++;
      if (mon_b != exp_q) begin
        failures++;
        $display("FAIL b2b_frames%0d: got %p, want %p", it, mon_b, exp_q);
      end
      checks++;
      if (dn_b.size() != 2 || st_b.size() != l1 + l2 || st_b[l1] - dn_b[0] != 2) begin
        failures++;
        $display("FAIL b2b_timing%0d: %0d done, %0d pulses, want 2 and %0d starting at once",
                 it, dn_b.size(), st_b.size(), l1 + l2);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    int l;
    logic [7:0] exp_c[$];
    for (int it = 0; it < 8; it++) begin
      do_reset();
      rand_busy = 1'b1;
      b = $urandom;
      l = $urandom_range(0, 7);
      send(b, 3'(l));
      tick(120);
      rand_busy = 1'b0;
      model_frame(b, l, 1'b0, 1'b1, 1'b1);
      checks++;
      if (mon_a != exp_q || dn_a.size() != ((l != 0) ? 1 : 0)) begin
        failures++;
        $display("FAIL rand_a%0d: len=%0d got %p (%0d done), want %p", it, l, mon_a,
                 dn_a.size(), exp_q);
      end
      exp_q.delete();
      model_frame(b, l, 1'b1, 1'b1, 1'b1);
      exp_c = exp_q;
      checks++;
      if (mon_c != exp_c || dn_c.size() != ((l != 0) ? 1 : 0)) begin
        failures++;
        $display("FAIL rand_c%0d: len=%0d got %p (%0d done), want %p", it, l, mon_c,
                 dn_c.size(), exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_first();
    test_busy_stall();
    test_len_edges();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
